// File: rtl/ssem_accumulator_unit.sv
// ssem_accumulator_unit: command-driven accumulator datapath for the SSEM.
// Accumulator, scratch register file and add/sub/negate ALU share one
// tri-state bus; a four-state FSM sequences each accepted command.
module ssem_accumulator_unit #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 4,
    parameter int OUT_HOLD = 2,
    localparam int REG_AW  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_reg,
    inout  wire  [WIDTH-1:0]  bus,
    output logic              done,
    output logic [WIDTH-1:0]  acc,
    output logic              negative,
    output logic              zero,
    output logic              overflow
);

    localparam int CW = (OUT_HOLD < 2) ? 1 : $clog2(OUT_HOLD);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DRIVE, S_DONE} state_t;
    typedef enum logic [2:0] {
        OP_NOP = 3'd0, OP_LDA = 3'd1, OP_LDN = 3'd2, OP_ADD = 3'd3,
        OP_SUB = 3'd4, OP_STR = 3'd5, OP_OUT = 3'd6, OP_LDR = 3'd7
    } op_t;

    state_t            r_state, w_next;
    logic [2:0]        r_op;
    logic [REG_AW-1:0] r_idx;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_regs [NUM_REGS];
    logic              r_neg, r_zero, r_ovf;

    logic [WIDTH-1:0]  w_bus, w_opnd, w_res;
    logic              w_ovf, w_flag;

    assign w_bus  = bus;
    assign w_opnd = r_regs[r_idx];

    // Bus is only ever driven while in DRIVE; reset drops the state and so releases it at once.
    assign bus = (r_state == S_DRIVE) ? r_acc : {WIDTH{1'bz}};

    assign acc      = r_acc;
    assign negative = r_neg;
    assign zero     = r_zero;
    assign overflow = r_ovf;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic and handshake/completion outputs.
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_next = S_EXEC;
            end
            S_EXEC:  w_next = (r_op == OP_OUT) ? S_DRIVE : S_DONE;
            S_DRIVE: if (r_cnt == '0) w_next = S_DONE;
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Capture opcode and register index at acceptance so later cmd_* changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op  <= '0;
            r_idx <= '0;
        end else if (r_state == S_IDLE && cmd_valid) begin
            r_op  <= cmd_op;
            r_idx <= cmd_reg;
        end
    end

    // DRIVE down-counter: loaded in EXEC so DRIVE lasts exactly OUT_HOLD cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                 r_cnt <= '0;
        else if (r_state == S_EXEC)                r_cnt <= CW'(OUT_HOLD - 1);
        else if (r_state == S_DRIVE && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end

    // ALU result and overflow for the flag-updating ops.
    always_comb begin
        w_res  = r_acc;
        w_ovf  = r_ovf;
        w_flag = 1'b0;
        case (r_op)
            OP_LDA: begin
                w_res  = w_bus;
                w_ovf  = 1'b0;
                w_flag = 1'b1;
            end
            OP_LDN: begin
                w_res  = '0 - w_bus;
                w_ovf  = (w_bus == MOST_NEG);
                w_flag = 1'b1;
            end
            OP_ADD: begin
                w_res  = r_acc + w_opnd;
                w_ovf  = (r_acc[WIDTH-1] == w_opnd[WIDTH-1]) &&
                         (w_res[WIDTH-1] != r_acc[WIDTH-1]);
                w_flag = 1'b1;
            end
            OP_SUB: begin
                w_res  = r_acc - w_opnd;
                w_ovf  = (r_acc[WIDTH-1] != w_opnd[WIDTH-1]) &&
                         (w_res[WIDTH-1] != r_acc[WIDTH-1]);
                w_flag = 1'b1;
            end
            default: ;
        endcase
    end

    // Accumulator and flags commit at the closing edge of EXEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc  <= '0;
            r_neg  <= 1'b0;
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (r_state == S_EXEC && w_flag) begin
            r_acc  <= w_res;
            r_neg  <= w_res[WIDTH-1];
            r_zero <= (w_res == '0);
            r_ovf  <= w_ovf;
        end
    end

    // Scratch register writes (STR from acc, LDR from bus) at the EXEC commit edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (r_state == S_EXEC) begin
            if (r_op == OP_STR)      r_regs[r_idx] <= r_acc;
            else if (r_op == OP_LDR) r_regs[r_idx] <= w_bus;
        end
    end

endmodule

// File: tb/tb_ssem_accumulator_unit.sv
// Directed bench for ssem_accumulator_unit: default configuration (A) and
// WIDTH=16 / NUM_REGS=8 / OUT_HOLD=1 (B). Buses are pulled high, so a
// released bus reads as all ones.
module tb_ssem_accumulator_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // instance A: defaults
    logic        a_v = 0, a_rdy, a_done, a_n, a_z, a_o, a_den = 0;
    logic [2:0]  a_op = 0;
    logic [1:0]  a_rg = 0;
    logic [31:0] a_acc, a_drv = 0;
    tri1  [31:0] a_bus;
    assign a_bus = a_den ? a_drv : 32'bz;

    // instance B: parameter sweep
    logic        b_v = 0, b_rdy, b_done, b_n, b_z, b_o, b_den = 0;
    logic [2:0]  b_op = 0;
    logic [2:0]  b_rg = 0;
    logic [15:0] b_acc, b_drv = 0;
    tri1  [15:0] b_bus;
    assign b_bus = b_den ? b_drv : 16'bz;

    ssem_accumulator_unit dut_a (
        .clk(clk), .reset(rst), .cmd_valid(a_v), .cmd_ready(a_rdy),
        .cmd_op(a_op), .cmd_reg(a_rg), .bus(a_bus), .done(a_done),
        .acc(a_acc), .negative(a_n), .zero(a_z), .overflow(a_o)
    );

    ssem_accumulator_unit #(.WIDTH(16), .NUM_REGS(8), .OUT_HOLD(1)) dut_b (
        .clk(clk), .reset(rst), .cmd_valid(b_v), .cmd_ready(b_rdy),
        .cmd_op(b_op), .cmd_reg(b_rg), .bus(b_bus), .done(b_done),
        .acc(b_acc), .negative(b_n), .zero(b_z), .overflow(b_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic st(input bit sel, input string tag, input logic [31:0] e_acc,
                      input logic e_n, input logic e_z, input logic e_o);
        chk({tag, ".acc"}, sel ? {16'h0, b_acc} : a_acc, e_acc);
        chk({tag, ".neg"}, sel ? b_n : a_n, e_n);
        chk({tag, ".zero"}, sel ? b_z : a_z, e_z);
        chk({tag, ".ovf"}, sel ? b_o : a_o, e_o);
    endtask

    // One non-OUT command: accept at edge k, done expected in cycle k+1..k+2.
    task automatic cmd(input bit sel, input logic [2:0] op, input int rg,
                       input logic [31:0] data, input bit drv);
        logic [2:0] ri;
        ri = rg[2:0];
        @(negedge clk);
        chk("ready", sel ? b_rdy : a_rdy, 1);
        chk("done_idle", sel ? b_done : a_done, 0);
        if (!sel) begin
            a_v = 1; a_op = op; a_rg = ri[1:0]; a_drv = data; a_den = drv;
        end else begin
            b_v = 1; b_op = op; b_rg = ri; b_drv = data[15:0]; b_den = drv;
        end
        @(posedge clk); #1;
        a_v = 0; b_v = 0;
        @(negedge clk);
        chk("done_early", sel ? b_done : a_done, 0);
        @(posedge clk); #1;
        a_den = 0; b_den = 0;
        @(negedge clk);
        chk("done", sel ? b_done : a_done, 1);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        st(0, "rst_a", 32'h0, 0, 0, 0);
        chk("rst_a.bus", a_bus, 32'hFFFF_FFFF);
        rst = 0;
        @(negedge clk);
        chk("rst_a.ready", a_rdy, 1);
        chk("rst_a.done", a_done, 0);
        st(1, "rst_b", 32'h0, 0, 0, 0);

        // add
        cmd(0, 3'd1, 0, 32'd5, 1);
        st(0, "lda5", 32'd5, 0, 0, 0);
        cmd(0, 3'd7, 1, 32'd3, 1);
        cmd(0, 3'd3, 1, 32'd0, 0);
        st(0, "add", 32'h0000_0008, 0, 0, 0);

        // negative result, LDN, equal subtract
        cmd(0, 3'd1, 0, 32'd5, 1);
        cmd(0, 3'd7, 2, 32'd10, 1);
        cmd(0, 3'd4, 2, 32'd0, 0);
        st(0, "sub_neg", 32'hFFFF_FFFB, 1, 0, 0);
        cmd(0, 3'd2, 0, 32'h0000_000A, 1);
        st(0, "ldn", 32'hFFFF_FFF6, 1, 0, 0);
        cmd(0, 3'd5, 3, 32'd0, 0);
        cmd(0, 3'd4, 3, 32'd0, 0);
        st(0, "sub_eq", 32'h0, 0, 1, 0);

        // signed overflow
        cmd(0, 3'd1, 0, 32'h7FFF_FFFF, 1);
        cmd(0, 3'd7, 0, 32'd1, 1);
        cmd(0, 3'd3, 0, 32'd0, 0);
        st(0, "add_ovf", 32'h8000_0000, 1, 0, 1);
        cmd(0, 3'd0, 0, 32'd0, 0);
        st(0, "nop", 32'h8000_0000, 1, 0, 1);
        cmd(0, 3'd4, 0, 32'd0, 0);
        st(0, "sub_ovf", 32'h7FFF_FFFF, 0, 0, 1);
        cmd(0, 3'd1, 0, 32'd0, 1);
        st(0, "lda0", 32'h0, 0, 1, 0);

        // STR then OUT with cmd_valid held through DRIVE
        cmd(0, 3'd1, 0, 32'h1234_5678, 1);
        cmd(0, 3'd5, 3, 32'd0, 0);
        cmd(0, 3'd1, 0, 32'd0, 1);
        cmd(0, 3'd3, 3, 32'd0, 0);
        st(0, "str_add", 32'h1234_5678, 0, 0, 0);
        @(negedge clk);
        a_v = 1; a_op = 3'd6;
        @(posedge clk);
        @(negedge clk);
        chk("out.exec_bus", a_bus, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("out.drive1", a_bus, 32'h1234_5678);
        chk("out.ready_drive", a_rdy, 0);
        chk("out.done_drive", a_done, 0);
        @(negedge clk);
        chk("out.drive2", a_bus, 32'h1234_5678);
        @(negedge clk);
        chk("out.released", a_bus, 32'hFFFF_FFFF);
        chk("out.done", a_done, 1);
        a_v = 0;
        @(negedge clk);
        chk("out.done_once", a_done, 0);
        chk("out.ready", a_rdy, 1);
        chk("out.no_reaccept", a_bus, 32'hFFFF_FFFF);

        // LDN of most negative value, then reset in the middle of DRIVE
        cmd(0, 3'd2, 0, 32'h8000_0000, 1);
        st(0, "ldn_min", 32'h8000_0000, 1, 0, 1);
        @(negedge clk);
        a_v = 1; a_op = 3'd6;
        @(posedge clk); #1;
        a_v = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rdrive.bus", a_bus, 32'h8000_0000);
        #2 rst = 1;
        #1;
        chk("rdrive.bus_z", a_bus, 32'hFFFF_FFFF);
        st(0, "rdrive", 32'h0, 0, 0, 0);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rdrive.no_done", a_done, 0);
        end
        chk("rdrive.ready", a_rdy, 1);
        cmd(0, 3'd3, 3, 32'd0, 0);
        st(0, "regs_cleared", 32'h0, 0, 1, 0);

        // parameter sweep instance
        cmd(1, 3'd1, 0, 32'd5, 1);
        cmd(1, 3'd7, 7, 32'd3, 1);
        cmd(1, 3'd3, 7, 32'd0, 0);
        st(1, "b_add", 32'h0008, 0, 0, 0);
        cmd(1, 3'd7, 2, 32'd10, 1);
        cmd(1, 3'd1, 0, 32'd5, 1);
        cmd(1, 3'd4, 2, 32'd0, 0);
        st(1, "b_sub_neg", 32'hFFFB, 1, 0, 0);
        @(negedge clk);
        b_v = 1; b_op = 3'd6;
        @(posedge clk); #1;
        b_v = 0;
        @(negedge clk);
        chk("b_out.exec_bus", {16'h0, b_bus}, 32'h0000_FFFF);
        @(negedge clk);
        chk("b_out.drive", {16'h0, b_bus}, 32'h0000_FFFB);
        chk("b_out.done_drive", b_done, 0);
        @(negedge clk);
        chk("b_out.released", {16'h0, b_bus}, 32'h0000_FFFF);
        chk("b_out.done", b_done, 1);
        @(negedge clk);
        chk("b_out.done_once", b_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
